stream_sink_checker: RTL
========================

# stream_sink_checker

Terminal consumer for the valid/ready data pipeline: sits directly downstream of the last pipeline register stage and accepts its output stream. It generates pseudo-random back-pressure on `s_ready`, checks that accepted data forms an arithmetic sequence, and checks handshake protocol compliance. Counters and sticky flags are exported for the bench and for on-chip debug.

## Interface
- `DW`, 8, data width
- `CNT_W`, 16, width of beat and error counters
- `FIRST`, 0, expected value of the first accepted beat after reset
- `STEP`, 2, expected increment between consecutive accepted beats (mod 2^DW)
- `SEED`, 16'hACE1, LFSR reset value; must be non-zero
---
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `s_valid`  in  1  upstream data valid
- `s_ready`  out  1  sink ready, registered
- `s_data`  in  DW  upstream data
- `throttle_en`  in  1  1 = apply pseudo-random back-pressure
- `throttle_thr`  in  4  stall when `lfsr[3:0] < throttle_thr`; 0 = never stall, 15 = stall 15/16
- `beat_cnt`  out  CNT_W  accepted beats, saturating
- `err_cnt`  out  CNT_W  error events, saturating
- `err_seq`  out  1  sticky: sequence mismatch seen
- `err_proto`  out  1  sticky: protocol violation seen
- `exp_data`  out  DW  value expected on next accepted beat
- `last_data`  out  DW  most recent accepted data

## Operation
- Accept = `s_valid & s_ready` at a rising edge.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. Advances every cycle outside reset, independent of traffic.
- Ready: `s_ready <= !throttle_en | (lfsr_next[3:0] >= throttle_thr)`.
- On accept:
  - `beat_cnt` +1 (saturates at all-ones).
  - `last_data <= s_data`.
  - If `s_data != exp_data`, set `err_seq` and count an error event.
  - `exp_data <= s_data + STEP` (DW-bit wrap). Resyncing on the received value means a single bad beat counts once, not forever.
- Protocol FSM, two states:
  - IDLE: no pending beat. Goes to PEND when `s_valid & !s_ready`.
  - PEND: a beat was offered and refused; `s_data` is held in `pend_data`.
  - In PEND, next cycle requires `s_valid == 1` and `s_data == pend_data`. Otherwise set `err_proto` and count an error event.
  - From PEND: accept → IDLE. Still stalled → stay in PEND (re-capture data). `s_valid` dropped → IDLE after flagging.
- `err_cnt` increments by exactly 1 per cycle with any error, even if both sequence and protocol errors occur in the same cycle. Saturates.
- Sticky flags clear only on `rst`.

## Timing
- Reset values: `s_ready`=0, `beat_cnt`=0, `err_cnt`=0, `err_seq`=0, `err_proto`=0, `exp_data`=FIRST, `last_data`=0, LFSR=SEED, FSM=IDLE.
- First edge after `rst` falls: `s_ready` rises if unthrottled, so the earliest accept is on the second edge after reset release.
- All outputs are registered. Counters, flags and `exp_data` reflect an accept one cycle after the accepting edge.
- No combinational path from `s_valid`/`s_data` to `s_ready`.
- `rst` asserted mid-transfer: everything returns to reset values at that edge. A pending beat is discarded with no error.
- `throttle_thr` and `throttle_en` changes take effect on the next `s_ready` update.

## Structure
- Shared package `stream_pkg`: LFSR polynomial constant, default seed, FSM state enum {IDLE, PEND}.
- Sub-module `sink_lfsr` (16-bit Galois LFSR with seed parameter, outputs current and next state). Reused by future source-side throttles.
- Counters, checker and FSM are inline in `stream_sink_checker`.

## Test plan
- **Reset, no traffic.** Hold `rst` 2 cycles, then `s_valid`=0 for 10 cycles → all outputs at reset values, except `s_ready`=1 from the first post-reset edge (`throttle_en`=0).
- **Clean stream.** Source drives 0,2,4,…,38 with valid held high, `throttle_en`=0 → `beat_cnt`=20, `err_cnt`=0, `exp_data`=40, `last_data`=38.
- **Throttled stream.** `throttle_en`=1, `throttle_thr`=8, 100 beats of 0,2,4,… → `beat_cnt`=100, no errors, and `s_ready` low on at least 30% of cycles.
- **Sequence error.** Inject 7 in place of 6 in stream 0,2,4,6,8,… → `err_seq`=1, `err_cnt`=1, and after the next beat (9) `exp_data`=11 with no further errors.
- **Protocol errors.** While stalled (`throttle_thr`=15), change `s_data` 4→5 → `err_proto`=1, `err_cnt`=1. Separately, drop `s_valid` during a stall → `err_cnt`=2.
- **Saturation and mid-run reset.** With `CNT_W`=4, send 20 clean beats → `beat_cnt`=15. Assert `rst` during a stall → all outputs return to reset values, no error flagged.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared definitions for valid/ready stream endpoints: LFSR constants and
// the pending-beat tracker state encoding.
package stream_pkg;

  // Right-shift Galois mask for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } pend_state_t;

endpackage

// File: rtl/sink_lfsr.sv
// 16-bit Galois LFSR, free-running outside reset; exposes both the current
// state and the value it will load on the next edge.
module sink_lfsr
  import stream_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr,
  output logic [15:0] lfsr_next
);

  always_comb begin
    lfsr_next = {1'b0, lfsr[15:1]};
    if (lfsr[0]) lfsr_next = lfsr_next ^ LFSR_POLY;
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr <= SEED;
    else     lfsr <= lfsr_next;
  end

endmodule

// File: rtl/stream_sink_checker.sv
// Terminal stream consumer: pseudo-random back-pressure, arithmetic sequence
// checking and valid/ready protocol checking with saturating debug counters.
module stream_sink_checker
  import stream_pkg::*;
#(
  parameter int          DW    = 8,
  parameter int          CNT_W = 16,
  parameter logic [DW-1:0] FIRST = '0,
  parameter logic [DW-1:0] STEP  = DW'(2),
  parameter logic [15:0] SEED  = LFSR_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DW-1:0]    s_data,
  input  logic             throttle_en,
  input  logic [3:0]       throttle_thr,
  output logic [CNT_W-1:0] beat_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_seq,
  output logic             err_proto,
  output logic [DW-1:0]    exp_data,
  output logic [DW-1:0]    last_data
);

  logic [15:0] lfsr, lfsr_next;
  logic        lfsr_unused;

  sink_lfsr #(.SEED(SEED)) u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .lfsr      (lfsr),
    .lfsr_next (lfsr_next)
  );

  // Only the low nibble drives the throttle decision.
  assign lfsr_unused = ^{lfsr, lfsr_next[15:4]};

  pend_state_t    state;
  logic [DW-1:0]  pend_data;
  logic           accept, seq_err, proto_err;

  always_comb begin
    accept    = s_valid & s_ready;
    seq_err   = accept && (s_data != exp_data);
    proto_err = (state == PEND) && (!s_valid || (s_data != pend_data));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_ready   <= 1'b0;
      beat_cnt  <= '0;
      err_cnt   <= '0;
      err_seq   <= 1'b0;
      err_proto <= 1'b0;
      exp_data  <= FIRST;
      last_data <= '0;
      state     <= IDLE;
      pend_data <= '0;
    end else begin
      // Decided from the LFSR alone, so no path from the upstream inputs.
      s_ready <= !throttle_en || (lfsr_next[3:0] >= throttle_thr);

      if (accept) begin
        if (beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
        last_data <= s_data;
        // Resync on what arrived so one bad beat is counted once.
        exp_data  <= s_data + STEP;
      end

      if (seq_err)   err_seq   <= 1'b1;
      if (proto_err) err_proto <= 1'b1;
      if ((seq_err || proto_err) && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;

      unique case (state)
        IDLE: if (s_valid && !s_ready) begin
          state     <= PEND;
          pend_data <= s_data;
        end
        PEND: begin
          if (s_valid && !s_ready) pend_data <= s_data;
          else                     state     <= IDLE;
        end
      endcase
    end
  end

endmodule
